// File: rtl/bsg_cache_nb_pkg.sv
// Shared types for the non-blocking cache: load size encoding and the
// read-miss queue entry consumed by the miss-response drain.
package bsg_cache_nb_pkg;

    localparam int unsigned block_size_in_words_gp = 8;
    localparam int unsigned word_width_gp          = 64;
    localparam int unsigned src_id_width_gp        = 4;
    localparam int unsigned mshr_els_gp            = 4;

    localparam int unsigned word_bytes_gp      = word_width_gp / 8;
    localparam int unsigned lg_word_bytes_gp   = (word_bytes_gp == 1) ? 1 : $clog2(word_bytes_gp);
    localparam int unsigned lg_block_words_gp  = (block_size_in_words_gp == 1) ? 1 : $clog2(block_size_in_words_gp);
    localparam int unsigned lg_mshr_els_gp     = (mshr_els_gp == 1) ? 1 : $clog2(mshr_els_gp);

    typedef enum logic [1:0] {
        e_size_b1 = 2'd0,
        e_size_b2 = 2'd1,
        e_size_b4 = 2'd2,
        e_size_b8 = 2'd3
    } size_op_e;

    typedef struct packed {
        logic [src_id_width_gp-1:0]   src_id;
        logic [lg_block_words_gp-1:0] word_offset;
        logic [lg_word_bytes_gp-1:0]  byte_sel;
        logic [word_bytes_gp-1:0]     mask;
        size_op_e                     size_op;
        logic                         sigext_op;
        logic                         mask_op;
        logic [word_width_gp-1:0]     mshr_data;
        logic [word_bytes_gp-1:0]     mshr_data_mask;
    } bsg_cache_nb_read_miss_entry_s;

endpackage

// File: rtl/bsg_cache_nb_load_extract.sv
// Combinational load formatter: merges pending store bytes into the fetched word,
// then applies byte masking or size extraction with optional sign extension.
module bsg_cache_nb_load_extract
    import bsg_cache_nb_pkg::*;
#(
    parameter  int unsigned word_width_p = word_width_gp,
    localparam int unsigned bytes_lp     = word_width_p / 8,
    localparam int unsigned lg_bytes_lp  = (bytes_lp == 1) ? 1 : $clog2(bytes_lp),
    localparam int unsigned lg_width_lp  = $clog2(word_width_p)
) (
    input  logic [word_width_p-1:0] word_i,
    input  logic [word_width_p-1:0] mshr_data_i,
    input  logic [bytes_lp-1:0]     mshr_data_mask_i,
    input  logic [bytes_lp-1:0]     mask_i,
    input  logic [lg_bytes_lp-1:0]  byte_sel_i,
    input  size_op_e                size_op_i,
    input  logic                    sigext_i,
    input  logic                    mask_op_i,
    output logic [word_width_p-1:0] data_o
);

    logic [word_width_p-1:0] merged;
    logic [word_width_p-1:0] shifted;
    logic [1:0]              size_lg;
    logic [lg_bytes_lp-1:0]  aligned;
    logic [31:0]             nbits;
    logic [lg_width_lp-1:0]  sign_idx;
    logic                    sign_b;

    always_comb begin
        merged   = '0;
        shifted  = '0;
        size_lg  = 2'(size_op_i);
        aligned  = '0;
        nbits    = '0;
        sign_idx = '0;
        sign_b   = 1'b0;
        data_o   = '0;

        for (int unsigned b = 0; b < bytes_lp; b++) begin
            merged[8*b +: 8] = mshr_data_mask_i[b] ? mshr_data_i[8*b +: 8] : word_i[8*b +: 8];
        end

        // Sizes wider than the word collapse to a full-word access.
        if (32'(size_op_i) > lg_bytes_lp) begin
            size_lg = 2'(lg_bytes_lp);
        end
        aligned  = byte_sel_i & ({lg_bytes_lp{1'b1}} << size_lg);
        shifted  = merged >> {aligned, 3'b000};
        nbits    = 32'd8 << size_lg;
        sign_idx = lg_width_lp'(nbits - 32'd1);
        sign_b   = sigext_i & shifted[sign_idx];

        if (mask_op_i) begin
            for (int unsigned b = 0; b < bytes_lp; b++) begin
                data_o[8*b +: 8] = mask_i[b] ? merged[8*b +: 8] : 8'h00;
            end
        end else begin
            for (int unsigned i = 0; i < word_width_p; i++) begin
                data_o[i] = (i < nbits) ? shifted[i] : sign_b;
            end
        end
    end

endmodule

// File: rtl/bsg_cache_nb_read_miss_resp.sv
// Drains one MSHR's queued read misses after its refill and returns formatted load
// responses. Define BSG_CACHE_NB_READ_MISS_RESP_SKID_EN for a 2-entry skid output stage.
module bsg_cache_nb_read_miss_resp
    import bsg_cache_nb_pkg::*;
#(
    parameter  int unsigned block_size_in_words_p = block_size_in_words_gp,
    parameter  int unsigned word_width_p          = word_width_gp,
    parameter  int unsigned src_id_width_p        = src_id_width_gp,
    parameter  int unsigned mshr_els_p            = mshr_els_gp,
    localparam int unsigned lg_mshr_els_lp        = (mshr_els_p == 1) ? 1 : $clog2(mshr_els_p),
    localparam int unsigned block_width_lp        = block_size_in_words_p * word_width_p
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          refill_v_i,
    output logic                          refill_yumi_o,
    input  logic [lg_mshr_els_lp-1:0]     mshr_id_i,
    input  logic [block_width_lp-1:0]     block_data_i,
    output logic                          rmq_v_o,
    output logic [lg_mshr_els_lp-1:0]     rmq_mshr_id_o,
    input  bsg_cache_nb_read_miss_entry_s rmq_entry_i,
    output logic                          rmq_yumi_o,
    input  logic                          rmq_done_i,
    output logic                          v_o,
    input  logic                          ready_i,
    output logic [src_id_width_p-1:0]     src_id_o,
    output logic [word_width_p-1:0]       data_o,
    output logic                          drain_done_o
);

    typedef enum logic [2:0] {
        e_idle,
        e_start,
        e_wait,
        e_serve,
        e_done
    } state_e;

    state_e                      state_q, state_d;
    logic [block_width_lp-1:0]   block_q, block_d;
    logic [lg_mshr_els_lp-1:0]   mshr_id_q, mshr_id_d;
    logic                        pop;
    logic                        load;
    logic [word_width_p-1:0]     word_sel;
    logic [word_width_p-1:0]     fmt_data;
    logic [src_id_width_p-1:0]   fmt_id;

    assign word_sel = block_q[word_width_p*32'(rmq_entry_i.word_offset) +: word_width_p];
    assign fmt_id   = src_id_width_p'(rmq_entry_i.src_id);

    bsg_cache_nb_load_extract #(
        .word_width_p(word_width_p)
    ) extract (
        .word_i          (word_sel),
        .mshr_data_i     (rmq_entry_i.mshr_data),
        .mshr_data_mask_i(rmq_entry_i.mshr_data_mask),
        .mask_i          (rmq_entry_i.mask),
        .byte_sel_i      (rmq_entry_i.byte_sel),
        .size_op_i       (rmq_entry_i.size_op),
        .sigext_i        (rmq_entry_i.sigext_op),
        .mask_op_i       (rmq_entry_i.mask_op),
        .data_o          (fmt_data)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= e_idle;
            block_q   <= '0;
            mshr_id_q <= '0;
        end else begin
            state_q   <= state_d;
            block_q   <= block_d;
            mshr_id_q <= mshr_id_d;
        end
    end

    // Drain sequencing: capture refill, kick the queue read, pop entries, signal done.
    always_comb begin
        state_d       = state_q;
        block_d       = block_q;
        mshr_id_d     = mshr_id_q;
        refill_yumi_o = 1'b0;
        rmq_v_o       = 1'b0;
        pop           = 1'b0;
        drain_done_o  = 1'b0;
        case (state_q)
            e_idle: begin
                if (refill_v_i) begin
                    refill_yumi_o = 1'b1;
                    block_d       = block_data_i;
                    mshr_id_d     = mshr_id_i;
                    state_d       = e_start;
                end
            end
            e_start: begin
                rmq_v_o = 1'b1;
                state_d = e_wait;
            end
            e_wait: begin
                state_d = e_serve;
            end
            e_serve: begin
                pop = load;
                if (load && rmq_done_i) begin
                    state_d = e_done;
                end
            end
            e_done: begin
                drain_done_o = 1'b1;
                state_d      = e_idle;
            end
            default: begin
                state_d = e_idle;
            end
        endcase
    end

    assign rmq_yumi_o    = pop;
    assign rmq_mshr_id_o = mshr_id_q;

`ifdef BSG_CACHE_NB_READ_MISS_RESP_SKID_EN
    logic [1:0]                cnt_q, cnt_d;
    logic [src_id_width_p-1:0] id0_q, id0_d, id1_q, id1_d;
    logic [word_width_p-1:0]   data0_q, data0_d, data1_q, data1_d;

    // Space check only, so the pop never waits on ready_i combinationally.
    assign load = (cnt_q != 2'd2);

    always_comb begin
        cnt_d   = cnt_q;
        id0_d   = id0_q;
        id1_d   = id1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        case (cnt_q)
            2'd0: begin
                if (pop) begin
                    id0_d   = fmt_id;
                    data0_d = fmt_data;
                    cnt_d   = 2'd1;
                end
            end
            2'd1: begin
                if (pop && ready_i) begin
                    id0_d   = fmt_id;
                    data0_d = fmt_data;
                end else if (pop) begin
                    id1_d   = fmt_id;
                    data1_d = fmt_data;
                    cnt_d   = 2'd2;
                end else if (ready_i) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (ready_i) begin
                    id0_d   = id1_q;
                    data0_d = data1_q;
                    cnt_d   = 2'd1;
                end
            end
            default: begin
                cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            id0_q   <= '0;
            id1_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            id0_q   <= id0_d;
            id1_q   <= id1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign v_o      = (cnt_q != 2'd0);
    assign src_id_o = id0_q;
    assign data_o   = data0_q;
`else
    logic                      out_v_q, out_v_d;
    logic [src_id_width_p-1:0] out_id_q, out_id_d;
    logic [word_width_p-1:0]   out_data_q, out_data_d;

    assign load = ~out_v_q | ready_i;

    always_comb begin
        out_v_d    = out_v_q;
        out_id_d   = out_id_q;
        out_data_d = out_data_q;
        if (pop) begin
            out_v_d    = 1'b1;
            out_id_d   = fmt_id;
            out_data_d = fmt_data;
        end else if (ready_i) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_v_q    <= 1'b0;
            out_id_q   <= '0;
            out_data_q <= '0;
        end else begin
            out_v_q    <= out_v_d;
            out_id_q   <= out_id_d;
            out_data_q <= out_data_d;
        end
    end

    assign v_o      = out_v_q;
    assign src_id_o = out_id_q;
    assign data_o   = out_data_q;
`endif

endmodule

// File: tb/tb_bsg_cache_nb_read_miss_resp.sv
// Directed scoreboard bench for bsg_cache_nb_read_miss_resp with a behavioural read-miss queue.
module tb_bsg_cache_nb_read_miss_resp;
    import bsg_cache_nb_pkg::*;

`ifdef BSG_CACHE_NB_READ_MISS_RESP_SKID_EN
    localparam int STALL_POPS = 2;
`else
    localparam int STALL_POPS = 1;
`endif

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          reset_i;
    logic                          refill_v_i;
    logic                          refill_yumi_o;
    logic [1:0]                    mshr_id_i;
    logic [511:0]                  block_data_i;
    logic                          rmq_v_o;
    logic [1:0]                    rmq_mshr_id_o;
    bsg_cache_nb_read_miss_entry_s rmq_entry_i;
    logic                          rmq_yumi_o;
    logic                          rmq_done_i;
    logic                          v_o;
    logic                          ready_i;
    logic [3:0]                    src_id_o;
    logic [63:0]                   data_o;
    logic                          drain_done_o;

    bsg_cache_nb_read_miss_entry_s ent_arr [16];
    int                            ent_n;
    logic [4:0]                    idx;
    exp_t                          exp_q [$];
    logic [511:0]                  cur_blk;
    logic [1:0]                    exp_mshr;
    int                            vectors;
    int                            miscompares;
    int                            pops_cnt;
    int                            done_cnt;

    always #5 clk = ~clk;

    bsg_cache_nb_read_miss_resp dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .refill_v_i   (refill_v_i),
        .refill_yumi_o(refill_yumi_o),
        .mshr_id_i    (mshr_id_i),
        .block_data_i (block_data_i),
        .rmq_v_o      (rmq_v_o),
        .rmq_mshr_id_o(rmq_mshr_id_o),
        .rmq_entry_i  (rmq_entry_i),
        .rmq_yumi_o   (rmq_yumi_o),
        .rmq_done_i   (rmq_done_i),
        .v_o          (v_o),
        .ready_i      (ready_i),
        .src_id_o     (src_id_o),
        .data_o       (data_o),
        .drain_done_o (drain_done_o)
    );

    assign rmq_entry_i = (idx < 5'd16) ? ent_arr[idx[3:0]] : '0;
    assign rmq_done_i  = ((32'(idx) + 1) == ent_n);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-array reference: merge, then mask or size/align/extend.
    function automatic logic [63:0] model(input logic [511:0] blk, input bsg_cache_nb_read_miss_entry_s e);
        logic [63:0] w;
        logic [63:0] r;
        logic [7:0]  by [8];
        int          n;
        int          st;
        w = blk[64*int'(e.word_offset) +: 64];
        for (int b = 0; b < 8; b++) by[b] = e.mshr_data_mask[b] ? e.mshr_data[8*b +: 8] : w[8*b +: 8];
        r = '0;
        if (e.mask_op) begin
            for (int b = 0; b < 8; b++) if (e.mask[b]) r[8*b +: 8] = by[b];
        end else begin
            n  = 1 << int'(e.size_op);
            st = (int'(e.byte_sel) / n) * n;
            for (int b = 0; b < n; b++) r[8*b +: 8] = by[st+b];
            if (e.sigext_op && r[8*n-1]) for (int b = n; b < 8; b++) r[8*b +: 8] = 8'hFF;
        end
        return r;
    endfunction

    task automatic add_entry(input logic [3:0] src, input logic [2:0] off, input logic [2:0] bsel,
                             input logic [1:0] size, input logic sig, input logic mop, input logic [7:0] mask,
                             input logic [63:0] mdata, input logic [7:0] mdmask);
        bsg_cache_nb_read_miss_entry_s e;
        exp_t x;
        e.src_id = src; e.word_offset = off; e.byte_sel = bsel; e.mask = mask;
        e.size_op = size_op_e'(size); e.sigext_op = sig; e.mask_op = mop;
        e.mshr_data = mdata; e.mshr_data_mask = mdmask;
        ent_arr[ent_n] = e;
        ent_n++;
        x.id   = src;
        x.data = model(cur_blk, e);
        exp_q.push_back(x);
    endtask

    // One clock: check outputs at the falling edge, then advance the queue model.
    task automatic tick();
        logic s_start, s_yumi;
        exp_t x;
        @(negedge clk);
        if (v_o && ready_i) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL resp_extra observed=id %h data %h expected=none", src_id_o, data_o);
            end
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("resp_id", 64'(src_id_o), 64'(x.id));
                chk("resp_data", data_o, x.data);
            end
        end
`ifndef BSG_CACHE_NB_READ_MISS_RESP_SKID_EN
        if (v_o && !ready_i) chk("stall_no_pop", 64'(rmq_yumi_o), 64'd0);
`endif
        if (rmq_v_o) chk("rmq_mshr_id", 64'(rmq_mshr_id_o), 64'(exp_mshr));
        if (drain_done_o) done_cnt++;
        s_start = rmq_v_o;
        s_yumi  = rmq_yumi_o;
        if (s_yumi) pops_cnt++;
        @(posedge clk);
        #1;
        if (s_start) idx = '0;
        else if (s_yumi) idx = idx + 5'd1;
    endtask

    task automatic start_refill(input logic [1:0] mshr);
        exp_mshr     = mshr;
        done_cnt     = 0;
        pops_cnt     = 0;
        refill_v_i   = 1'b1;
        mshr_id_i    = mshr;
        block_data_i = cur_blk;
        #1;
        chk("refill_yumi", 64'(refill_yumi_o), 64'd1);
        tick();
        refill_v_i   = 1'b0;
        block_data_i = ~cur_blk;
        refill_v_i   = 1'b1;
        #1;
        chk("refill_ignored", 64'(refill_yumi_o), 64'd0);
        refill_v_i   = 1'b0;
    endtask

    task automatic finish_drain(input logic [3:0] pat, input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            ready_i = pat[c % 4];
            tick();
            if (done_cnt != 0 && exp_q.size() == 0) break;
        end
        chk("drain_done_cnt", 64'(done_cnt), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        ready_i = 1'b0;
        ent_n   = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; ent_n = 0; idx = '0; pops_cnt = 0; done_cnt = 0;
        reset_i = 1'b0; refill_v_i = 1'b0; mshr_id_i = '0; block_data_i = '0; ready_i = 1'b0;
        exp_mshr = '0; cur_blk = '0;
        for (int i = 0; i < 16; i++) ent_arr[i] = '0;
        #1 reset_i = 1'b1;
        #2;
        chk("rst_v_o", 64'(v_o), 64'd0);
        chk("rst_rmq_v_o", 64'(rmq_v_o), 64'd0);
        chk("rst_rmq_yumi_o", 64'(rmq_yumi_o), 64'd0);
        chk("rst_refill_yumi_o", 64'(refill_yumi_o), 64'd0);
        chk("rst_drain_done_o", 64'(drain_done_o), 64'd0);
        chk("rst_data_o", data_o, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;

        // Word k of the block is 0x1111_1111_1111_1111 * k.
        for (int k = 0; k < 8; k++) cur_blk[64*k +: 64] = 64'h1111_1111_1111_1111 * 64'(k);

        // Single full-word entry.
        add_entry(4'h5, 3'd3, 3'd0, 2'd3, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        start_refill(2'd2);
        finish_drain(4'b1111, 20);

        // Sub-word extraction with and without sign extension.
        cur_blk[64+40 +: 8] = 8'h80;
        add_entry(4'h1, 3'd1, 3'd5, 2'd0, 1'b1, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'h2, 3'd1, 3'd5, 2'd0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'h3, 3'd1, 3'd5, 2'd1, 1'b1, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'h4, 3'd1, 3'd6, 2'd2, 1'b1, 1'b0, 8'h00, 64'h0, 8'h00);
        start_refill(2'd1);
        finish_drain(4'b1111, 30);

        // Pending store bytes merged over the fetched word, plus masked loads.
        cur_blk[128 +: 64] = 64'h5555_5555_5555_5555;
        add_entry(4'h6, 3'd2, 3'd0, 2'd3, 1'b0, 1'b0, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        add_entry(4'h7, 3'd2, 3'd0, 2'd3, 1'b0, 1'b1, 8'hF0, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        add_entry(4'h8, 3'd2, 3'd0, 2'd3, 1'b0, 1'b1, 8'h3C, 64'h0, 8'h00);
        start_refill(2'd3);
        finish_drain(4'b1111, 30);

        // Four entries with ready_i toggling 1,0,1,0.
        add_entry(4'h9, 3'd7, 3'd0, 2'd3, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'hA, 3'd1, 3'd7, 2'd0, 1'b1, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'hB, 3'd4, 3'd3, 2'd1, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'hC, 3'd6, 3'd4, 2'd2, 1'b1, 1'b0, 8'h00, 64'h0123_4567_89AB_CDEF, 8'hC3);
        start_refill(2'd0);
        finish_drain(4'b0101, 40);

        // ready_i held low: output stage fills and popping stops without losing data.
        add_entry(4'hD, 3'd5, 3'd0, 2'd3, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'hE, 3'd6, 3'd2, 2'd1, 1'b1, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'hF, 3'd7, 3'd1, 2'd0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'h0, 3'd0, 3'd0, 2'd3, 1'b0, 1'b0, 8'h00, 64'hDEAD_BEEF_0000_FFFF, 8'h33);
        start_refill(2'd2);
        ready_i = 1'b0;
        repeat (8) tick();
        chk("stall_pops", 64'(pops_cnt), 64'(STALL_POPS));
        chk("stall_yumi", 64'(rmq_yumi_o), 64'd0);
        chk("stall_v_o", 64'(v_o), 64'd1);
        finish_drain(4'b1111, 30);

        // Asynchronous reset while a response is waiting.
        add_entry(4'h3, 3'd2, 3'd0, 2'd3, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'h4, 3'd3, 3'd0, 2'd3, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'h5, 3'd4, 3'd0, 2'd3, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        start_refill(2'd3);
        ready_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (v_o) break;
            tick();
        end
        chk("pre_reset_v_o", 64'(v_o), 64'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("async_rst_v_o", 64'(v_o), 64'd0);
        chk("async_rst_data_o", data_o, 64'd0);
        chk("async_rst_src_id_o", 64'(src_id_o), 64'd0);
        exp_q.delete();
        ent_n = 0;
        @(posedge clk);
        #1 reset_i = 1'b0;

        // Normal drain after the abort.
        add_entry(4'h2, 3'd6, 3'd0, 2'd3, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
        add_entry(4'h7, 3'd1, 3'd5, 2'd0, 1'b1, 1'b0, 8'h00, 64'h0, 8'h00);
        start_refill(2'd1);
        finish_drain(4'b1111, 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
